// File: rtl/wave_bank.sv
// Multi-channel phase-accumulator waveform bank: per-channel waveform synthesis,
// amplitude scaling and a saturating pipelined adder tree into one summed sample.
module wave_bank #(
  parameter int NUM_CH = 16,
  parameter int DW     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        activein,
  input  logic signed [NUM_CH*DW-1:0] amps,
  input  logic        [NUM_CH*DW-1:0] offsets,
  input  logic        [NUM_CH*DW-1:0] phasewords,
  input  logic        [NUM_CH*2-1:0]  modes,
  input  logic        [NUM_CH-1:0]    chan_en,
  output logic signed [DW-1:0]        results,
  output logic                        activeout
);

  localparam int LOG = $clog2(NUM_CH);

  // Handshake: activein is a strobe with no backpressure. Every cycle it is high
  // launches exactly one sample, and activeout pulses for exactly one cycle when
  // that sample lands in results, 2+LOG cycles later, in launch order.

  // Phase accumulators and stage-1 registers
  logic        [DW-1:0]  acc   [NUM_CH];
  logic        [DW-1:0]  p1    [NUM_CH];
  logic        [1:0]     mode1 [NUM_CH];
  logic        [NUM_CH-1:0] en1;
  logic                  v1;

  // Heap-ordered tree: node n has children 2n+1 (lower index) and 2n+2.
  // Leaves NUM_CH-1 .. 2*NUM_CH-2 hold the stage-2 scaled channel samples;
  // the root (node 0) is the results register itself.
  logic signed [DW-1:0]  node  [1:2*NUM_CH-2];

  // vd[d] is the valid bit of the data held at tree depth d (leaves at LOG)
  logic        [LOG:1]   vd;

  function automatic logic signed [DW-1:0] wave_of(input logic [DW-1:0] p,
                                                   input logic [1:0]    m);
    logic [DW-2:0] q;
    q = p[DW-1] ? ~p[DW-2:0] : p[DW-2:0];
    case (m)
      2'b00:   wave_of = {~p[DW-1], p[DW-2:0]};
      2'b01:   wave_of = p[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      2'b10:   wave_of = {~q[DW-2], q[DW-3:0], 1'b0};
      default: wave_of = '0;
    endcase
  endfunction

  // Q1.15 scale with floor shift; only -1.0 * -1.0 can overflow
  function automatic logic signed [DW-1:0] scale(input logic signed [DW-1:0] w,
                                                 input logic signed [DW-1:0] a);
    logic signed [2*DW-1:0] prod;
    logic signed [2*DW-1:0] sh;
    prod = $signed({{DW{w[DW-1]}}, w}) * $signed({{DW{a[DW-1]}}, a});
    sh   = prod >>> (DW-1);
    if (sh[2*DW-1:DW-1] == '0 || sh[2*DW-1:DW-1] == '1)
      scale = sh[DW-1:0];
    else
      scale = sh[2*DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction

  function automatic logic signed [DW-1:0] sat_add(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
    logic [DW:0] sum;
    sum = {a[DW-1], a} + {b[DW-1], b};
    if (sum[DW] == sum[DW-1])
      sat_add = sum[DW-1:0];
    else
      sat_add = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]   <= '0;
        p1[i]    <= '0;
        mode1[i] <= '0;
      end
      for (int n = 1; n <= 2*NUM_CH-2; n++) begin
        node[n] <= '0;
      end
      en1       <= '0;
      v1        <= 1'b0;
      vd        <= '0;
      results   <= '0;
      activeout <= 1'b0;
    end else begin
      // Stage 1: phase uses the accumulator value from before this update
      v1  <= activein;
      en1 <= chan_en;
      for (int i = 0; i < NUM_CH; i++) begin
        p1[i]    <= acc[i] + offsets[DW*i +: DW];
        mode1[i] <= modes[2*i +: 2];
        if (activein) begin
          acc[i] <= acc[i] + phasewords[DW*i +: DW];
        end
      end

      // Stage 2: waveform and amplitude, amps taken in this cycle
      vd[LOG] <= v1;
      for (int i = 0; i < NUM_CH; i++) begin
        node[NUM_CH-1+i] <= en1[i] ? scale(wave_of(p1[i], mode1[i]), amps[DW*i +: DW])
                                   : '0;
      end

      // Interior tree levels, each clipped on its own
      for (int d = 1; d < LOG; d++) begin
        vd[d] <= vd[d+1];
      end
      for (int n = 1; n <= NUM_CH-2; n++) begin
        node[n] <= sat_add(node[2*n+1], node[2*n+2]);
      end

      // Root: results only moves when a valid sample arrives
      activeout <= vd[1];
      if (vd[1]) begin
        results <= sat_add(node[1], node[2]);
      end
    end
  end

endmodule

// File: tb/tb_wave_bank.sv
// Bench for wave_bank (4 channels): directed scenarios plus randomized traffic
// against an arithmetic reference model of the sample pipeline.
module tb_wave_bank;

  localparam int NUM_CH = 4;
  localparam int DW     = 16;
  localparam int L      = 2 + $clog2(NUM_CH);

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        activein;
  logic signed [NUM_CH*16-1:0] amps;
  logic        [NUM_CH*16-1:0] offsets;
  logic        [NUM_CH*16-1:0] phasewords;
  logic        [NUM_CH*2-1:0]  modes;
  logic        [NUM_CH-1:0]    chan_en;
  logic signed [15:0]          results;
  logic                        activeout;

  int checks = 0;
  int errors = 0;

  wave_bank #(.NUM_CH(NUM_CH), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .activein   (activein),
    .amps       (amps),
    .offsets    (offsets),
    .phasewords (phasewords),
    .modes      (modes),
    .chan_en    (chan_en),
    .results    (results),
    .activeout  (activeout)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_acc     [NUM_CH];
  int          pend_p    [NUM_CH];
  int          pend_en   [NUM_CH];
  int          pend_mode [NUM_CH];
  bit          pend_v = 1'b0;
  int          edge_n = 0;
  logic [15:0] exp_q [$];
  int          due_q [$];
  logic [15:0] exp_res = '0;
  logic        exp_act = 1'b0;

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int wave(input int p, input int mode);
    int q;
    case (mode)
      0: return p - 32768;
      1: return (p < 32768) ? 32767 : -32768;
      2: begin
        q = (p >= 32768) ? (65535 - p) : p;
        return 2 * q - 32768;
      end
      default: return 0;
    endcase
  endfunction

  // Uses the amplitudes present now (the cycle after launch)
  function automatic logic [15:0] model_sum();
    int lvl [NUM_CH];
    int n;
    int a;
    for (int i = 0; i < NUM_CH; i++) begin
      a = int'($signed(amps[16*i +: 16]));
      lvl[i] = pend_en[i] ? clamp16((wave(pend_p[i], pend_mode[i]) * a) >>> 15) : 0;
    end
    n = NUM_CH;
    while (n > 1) begin
      for (int j = 0; j < n / 2; j++) lvl[j] = clamp16(lvl[2*j] + lvl[2*j+1]);
      n = n / 2;
    end
    return 16'(lvl[0]);
  endfunction

  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) m_acc[i] = 0;
      pend_v  = 1'b0;
      exp_q.delete();
      due_q.delete();
      exp_res = '0;
      exp_act = 1'b0;
    end else begin
      if (pend_v) begin
        exp_q.push_back(model_sum());
        due_q.push_back(edge_n + L - 2);
      end
      pend_v = activein;
      if (activein) begin
        for (int i = 0; i < NUM_CH; i++) begin
          pend_p[i]    = (m_acc[i] + int'(offsets[16*i +: 16])) & 65535;
          pend_en[i]   = int'(chan_en[i]);
          pend_mode[i] = int'(modes[2*i +: 2]);
          m_acc[i]     = (m_acc[i] + int'(phasewords[16*i +: 16])) & 65535;
        end
      end
      exp_act = 1'b0;
      if (due_q.size() > 0 && due_q[0] == edge_n) begin
        exp_act = 1'b1;
        exp_res = exp_q.pop_front();
        void'(due_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_cfg();
    amps = '0; offsets = '0; phasewords = '0; modes = '0; chan_en = '0;
  endtask

  task automatic set_ch(input int i, input logic [1:0] m, input logic [15:0] a,
                        input logic [15:0] o, input logic [15:0] pw, input logic en);
    modes[2*i +: 2]       = m;
    amps[16*i +: 16]      = a;
    offsets[16*i +: 16]   = o;
    phasewords[16*i +: 16] = pw;
    chan_en[i]            = en;
  endtask

  task automatic do_reset();
    reset = 1'b1; activein = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_cfg();
    set_ch(0, 2'b00, 16'h4000, 16'h0000, 16'h1234, 1'b1);
    reset = 1'b1; activein = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (results !== 16'sd0) begin errors++; $display("FAIL reset_results c=%0d got=%0d want=0", c, results); end
      checks++;
      if (activeout !== 1'b0) begin errors++; $display("FAIL reset_activeout c=%0d got=%b want=0", c, activeout); end
    end
    reset = 1'b0;
    // accumulator must not have advanced: first sample has p=0 -> sawtooth -0.5
    for (int c = 1; c <= 5; c++) begin
      activein = (c == 1);
      @(negedge clk);
      checks++;
      if (activeout !== (c == 4)) begin errors++; $display("FAIL reset_first_act c=%0d got=%b want=%b", c, activeout, c == 4); end
      if (c == 4) begin
        checks++;
        if (results !== -16'sd16384) begin errors++; $display("FAIL reset_first_val got=%0d want=-16384", results); end
      end
    end
  endtask

  task automatic test_single_tone();
    do_reset();
    clear_cfg();
    set_ch(0, 2'b01, 16'h4000, 16'h0000, 16'h0000, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      activein = (c == 1);
      @(negedge clk);
      checks++;
      if (activeout !== (c == 4)) begin errors++; $display("FAIL tone_act c=%0d got=%b want=%b", c, activeout, c == 4); end
      checks++;
      if (results !== exp_res) begin errors++; $display("FAIL tone_model c=%0d got=%0d want=%0d", c, results, $signed(exp_res)); end
      if (c >= 4) begin
        checks++;
        if (results !== 16'sd16383) begin errors++; $display("FAIL tone_val c=%0d got=%0d want=16383", c, results); end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] want [4];
    want = '{16'sd32767, 16'sd32767, 16'sd32767, -16'sd32768};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      clear_cfg();
      for (int i = 0; i < NUM_CH; i++) begin
        case (k)
          0: set_ch(i, 2'b01, 16'h7FFF, 16'h0, 16'h0, 1'b1);
          1: set_ch(i, 2'b00, 16'h8000, 16'h0, 16'h0, 1'b1);
          2: set_ch(i, 2'b00, 16'h8000, 16'h0, 16'h0, i == 0);
          default: set_ch(i, 2'b00, 16'h7FFF, 16'h0, 16'h0, 1'b1);
        endcase
      end
      for (int c = 1; c <= 5; c++) begin
        activein = (c == 1);
        @(negedge clk);
        if (c == 4) begin
          checks++;
          if (activeout !== 1'b1) begin errors++; $display("FAIL sat_act k=%0d got=%b want=1", k, activeout); end
          checks++;
          if (results !== want[k]) begin errors++; $display("FAIL sat_val k=%0d got=%0d want=%0d", k, results, want[k]); end
          checks++;
          if (results !== exp_res) begin errors++; $display("FAIL sat_model k=%0d got=%0d want=%0d", k, results, $signed(exp_res)); end
        end
      end
    end
  endtask

  task automatic wrap_setup();
    do_reset();
    clear_cfg();
    set_ch(0, 2'b00, 16'h7FFF, 16'h0000, 16'h4000, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] want [5];
    want = '{-16'sd32767, -16'sd16384, 16'sd0, 16'sd16383, -16'sd32767};
    wrap_setup();
    for (int c = 1; c <= 9; c++) begin
      activein = (c <= 5);
      @(negedge clk);
      checks++;
      if (activeout !== (c >= 4 && c <= 8)) begin errors++; $display("FAIL b2b_act c=%0d got=%b want=%b", c, activeout, c >= 4 && c <= 8); end
      if (c >= 4) begin
        checks++;
        if (results !== want[(c <= 8) ? c - 4 : 4]) begin
          errors++; $display("FAIL b2b_val c=%0d got=%0d want=%0d", c, results, want[(c <= 8) ? c - 4 : 4]);
        end
      end
    end
  endtask

  task automatic test_gap();
    wrap_setup();
    for (int c = 1; c <= 8; c++) begin
      activein = (c == 1 || c == 4);
      @(negedge clk);
      checks++;
      if (activeout !== (c == 4 || c == 7)) begin errors++; $display("FAIL gap_act c=%0d got=%b want=%b", c, activeout, c == 4 || c == 7); end
      if (c >= 4) begin
        checks++;
        if (results !== ((c < 7) ? -16'sd32767 : -16'sd16384)) begin
          errors++; $display("FAIL gap_val c=%0d got=%0d want=%0d", c, results, (c < 7) ? -32767 : -16384);
        end
      end
    end
  endtask

  task automatic test_midstream_reset();
    wrap_setup();
    for (int c = 1; c <= 9; c++) begin
      reset = (c == 3);
      activein = 1'b1;
      @(negedge clk);
      checks++;
      if (activeout !== (c >= 7)) begin errors++; $display("FAIL mrst_act c=%0d got=%b want=%b", c, activeout, c >= 7); end
      if (c >= 3 && c <= 6) begin
        checks++;
        if (results !== 16'sd0) begin errors++; $display("FAIL mrst_clear c=%0d got=%0d want=0", c, results); end
      end
      if (c == 7 || c == 8) begin
        checks++;
        if (results !== ((c == 7) ? -16'sd32767 : -16'sd16384)) begin
          errors++; $display("FAIL mrst_val c=%0d got=%0d want=%0d", c, results, (c == 7) ? -32767 : -16384);
        end
      end
    end
    reset = 1'b0; activein = 1'b0;
  endtask

  task automatic test_random();
    int n_out = 0;
    do_reset();
    clear_cfg();
    for (int i = 0; i < NUM_CH; i++)
      set_ch(i, 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        set_ch($urandom_range(0, NUM_CH-1), 2'($urandom), 16'($urandom),
               16'($urandom), 16'($urandom), 1'($urandom));
      end
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < NUM_CH; i++) begin
          case ($urandom_range(0, 3))
            0: amps[16*i +: 16] = 16'h8000;
            1: amps[16*i +: 16] = 16'h7FFF;
            default: amps[16*i +: 16] = 16'($urandom);
          endcase
        end
      end
      activein = ($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      if (activeout === 1'b1) n_out++;
      checks++;
      if (activeout !== exp_act) begin errors++; $display("FAIL rand_act c=%0d got=%b want=%b", c, activeout, exp_act); end
      checks++;
      if (results !== exp_res) begin errors++; $display("FAIL rand_val c=%0d got=%0d want=%0d", c, results, $signed(exp_res)); end
    end
    reset = 1'b0; activein = 1'b0;
    checks++;
    if (n_out < 100) begin errors++; $display("FAIL rand_traffic got=%0d want>=100", n_out); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; activein = 1'b0;
    clear_cfg();
    repeat (3) @(negedge clk);
    test_reset();
    test_single_tone();
    test_saturation();
    test_back_to_back();
    test_gap();
    test_midstream_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
